tohost_snoop: RTL
=================

Name: tohost_snoop

Overview:
- Passive AXI write-channel monitor between the LEVE1 core's master port and the testbench RAM.
- Detects completed writes to the TOHOST mailbox word and produces the `tohost_we` / `tohost` pair that the testbench uses to declare pass/fail.
- Never drives or stalls the bus: every bus-facing port is an input.
- Tracks bursts, out-of-order AW/W arrival and write responses so that only acknowledged mailbox writes are reported.

Parameters:
TOHOST_ADDR, 32'h8000_1000, byte address of the 32-bit mailbox word (word aligned)
AW_DEPTH, 4, depth of the captured write-address queue
W_DEPTH, 8, depth of the captured write-data beat queue
B_DEPTH, 4, depth of the queue of completed transactions awaiting a response

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  in  1  write address ready
AWADDR  in  32  burst start byte address
AWLEN  in  8  beats minus one
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
WVALID  in  1  write data valid
WREADY  in  1  write data ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes
WLAST  in  1  last beat
BVALID  in  1  response valid
BREADY  in  1  response ready
BRESP  in  2  response code (00 OKAY)
tohost_we  out  1  one-cycle pulse: new mailbox value committed
tohost  out  32  committed mailbox value
mon_err  out  1  sticky protocol/overflow error

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTn is asynchronous and active-low.
- Reset values: all queues empty, beat counter 0, tohost=0, tohost_we=0, mon_err=0.
- Reset asserted mid-transaction discards all partial state. No pulse is generated for transactions in flight.
- Handshakes: a handshake is VALID&READY sampled at posedge CLK. AW, W and B captures are independent and may all occur in the same cycle.
- AW handshake: push {AWADDR, AWLEN, AWBURST} into the AW queue.
- W handshake: push {WDATA, WSTRB, WLAST} into the W queue. W may precede AW.
- Matching: when both queue heads are present, retire one W beat per cycle against the AW head.
  - Beat address, INCR: AWADDR + 4*beat.
  - Beat address, FIXED: AWADDR for every beat.
  - WRAP: sets mon_err and is treated as INCR.
- Hit: beat address == TOHOST_ADDR and WSTRB != 0. The transaction's staged value is the committed tohost with the strobed bytes replaced. Multiple hits in one burst: the last one wins.
- Burst close: pop the AW head and push {hit, staged} into the B queue when the retired beat has WLAST=1 or beat == AWLEN.
  - WLAST=1 with beat != AWLEN, or beat == AWLEN with WLAST=0: set mon_err, close at the earlier of the two.
  - Beat counter resets to 0 on close.
- Staged-value base: the base for staged is the committed tohost at match time. Two hit transactions outstanding together each merge from that base. Documented limitation.
- B handshake: pop the B queue head, in order.
  - hit=1 and BRESP==00: on the next posedge, tohost <= staged and tohost_we=1 for exactly one cycle.
  - hit=1 with BRESP!=00, or hit=0: no pulse, tohost unchanged.
- B with empty B queue: B handshake with the B queue empty, including a response arriving before its burst is matched, sets mon_err; the response is dropped.
- Queue overflow: push into a full queue sets mon_err and drops the pushed item. Simultaneous push and pop on a full queue is legal and does not overflow.
- Latency: tohost_we rises exactly 1 cycle after the qualifying B handshake.
  - Back-to-back qualifying B handshakes give back-to-back pulses, each with its own value.
- mon_err: cleared only by reset.

Test Plan:
- Single-beat INCR, AWADDR=TOHOST_ADDR, WDATA=0000_0001, WSTRB=F, AW before W, BRESP=00 → tohost_we pulses once exactly 1 cycle after B handshake; tohost=0000_0001; mon_err=0.
- W handshake 3 cycles before AW, same mailbox write of 0000_0007 → identical result, pulse only after B.
- INCR burst AWADDR=TOHOST_ADDR-8, AWLEN=3, beat 2 data=0000_002B, WSTRB=F → tohost=0000_002B. Same burst with beat 2 WSTRB=0001 over prior 0000_0001 → tohost=0000_002B (byte 0 only).
- Mailbox write answered BRESP=10 → no tohost_we, tohost holds previous value.
- AWLEN=1 with WLAST on beat 0 → mon_err=1 and the burst closes. BVALID&BREADY with no pending write → mon_err=1.
- Five AWs pushed with no W beats (AW_DEPTH=4) → mon_err=1. Deassert RSTn during an open mailbox burst → tohost=0, tohost_we never pulses, mon_err=0 after release.

Source files
------------

// File: rtl/tohost_snoop.sv
// Purpose: passive AXI write monitor; reports acknowledged writes to the TOHOST mailbox word.
// Latency: tohost_we/tohost update one cycle after the qualifying B handshake.
// Backpressure: none, since every bus port is an input; a push into a full queue is dropped and raises mon_err.
//
// Ports:
//   CLK, RSTn                              clock, async active-low reset
//   AW*/W*/B* (VALID, READY, payload)      observed AXI write channels (inputs only)
//   tohost_we                              one-cycle pulse when a new mailbox value is committed
//   tohost                                 committed mailbox value
//   mon_err                                sticky protocol/overflow error, cleared by reset only

// Generic FIFO used for the captured AW, W and B queues.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          wr_en;
    logic          rd_en;

    // A pop frees the slot at the same edge, so push-on-full with pop is accepted.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module tohost_snoop #(
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
    parameter int          AW_DEPTH    = 4,
    parameter int          W_DEPTH     = 8,
    parameter int          B_DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        AWVALID,
    input  logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic [1:0]  AWBURST,
    input  logic        WVALID,
    input  logic        WREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WLAST,
    input  logic        BVALID,
    input  logic        BREADY,
    input  logic [1:0]  BRESP,
    output logic        tohost_we,
    output logic [31:0] tohost,
    output logic        mon_err
);
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } aw_ent_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_ent_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] staged;
    } b_ent_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    aw_ent_t     aw_in, aw_head;
    w_ent_t      w_in, w_head;
    b_ent_t      b_in, b_head;
    logic        aw_push, aw_empty, aw_full;
    logic        w_push, w_empty, w_full;
    logic        b_hs, b_pop, b_empty, b_full;
    logic        match, close, len_end, beat_hit, err_set, commit;
    logic [31:0] beat_addr, merged;
    logic [7:0]  beat;
    logic        acc_hit;
    logic [31:0] acc_val;

    assign aw_push = AWVALID && AWREADY;
    assign w_push  = WVALID && WREADY;
    assign b_hs    = BVALID && BREADY;
    assign b_pop   = b_hs && !b_empty;
    assign aw_in   = '{addr: AWADDR, len: AWLEN, burst: AWBURST};
    assign w_in    = '{data: WDATA, strb: WSTRB, last: WLAST};

    fifo #(.W($bits(aw_ent_t)), .DEPTH(AW_DEPTH)) u_aw_q (
        .CLK(CLK), .RSTn(RSTn), .push(aw_push), .din(aw_in), .pop(close),
        .dout(aw_head), .empty(aw_empty), .full(aw_full)
    );

    fifo #(.W($bits(w_ent_t)), .DEPTH(W_DEPTH)) u_w_q (
        .CLK(CLK), .RSTn(RSTn), .push(w_push), .din(w_in), .pop(match),
        .dout(w_head), .empty(w_empty), .full(w_full)
    );

    fifo #(.W($bits(b_ent_t)), .DEPTH(B_DEPTH)) u_b_q (
        .CLK(CLK), .RSTn(RSTn), .push(close), .din(b_in), .pop(b_pop),
        .dout(b_head), .empty(b_empty), .full(b_full)
    );

    // One W beat retires per cycle against the AW head. WRAP is treated as INCR.
    always_comb begin
        match     = !aw_empty && !w_empty;
        len_end   = (beat == aw_head.len);
        close     = match && (w_head.last || len_end);
        beat_addr = (aw_head.burst == BURST_FIXED) ? aw_head.addr
                                                   : aw_head.addr + {22'd0, beat, 2'b00};
        beat_hit  = match && (beat_addr == TOHOST_ADDR) && (w_head.strb != 4'd0);
        // Staged value always merges onto the committed mailbox, so the last hit in a burst wins.
        merged    = tohost;
        for (int i = 0; i < 4; i++) begin
            if (w_head.strb[i]) begin
                merged[8*i +: 8] = w_head.data[8*i +: 8];
            end
        end
        b_in.hit    = acc_hit || beat_hit;
        b_in.staged = beat_hit ? merged : acc_val;
        commit      = b_pop && b_head.hit && (BRESP == 2'b00);
        err_set     = (aw_push && aw_full && !close)
                    || (w_push && w_full && !match)
                    || (close && b_full && !b_pop)
                    || (b_hs && b_empty)
                    || (match && (aw_head.burst == BURST_WRAP))
                    || (match && (w_head.last != len_end));
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            beat      <= '0;
            acc_hit   <= 1'b0;
            acc_val   <= '0;
            tohost_we <= 1'b0;
            tohost    <= '0;
            mon_err   <= 1'b0;
        end else begin
            if (close) begin
                beat    <= '0;
                acc_hit <= 1'b0;
                acc_val <= '0;
            end else if (match) begin
                beat <= beat + 8'd1;
                if (beat_hit) begin
                    acc_hit <= 1'b1;
                    acc_val <= merged;
                end
            end
            tohost_we <= commit;
            if (commit) begin
                tohost <= b_head.staged;
            end
            mon_err <= mon_err || err_set;
        end
    end
endmodule
